// File: rtl/ovr_i_monitor_pkg.sv
// Shared types and defaults for the over-current supervisor and its helpers.
package ovr_i_monitor_pkg;

  typedef enum logic [1:0] {RUN, FAULT, SHDN} ovr_state_t;

  localparam int unsigned TRIP_CNT_DEF    = 32;
  localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/ovr_i_monitor_sync_ff.sv
// Reset-to-zero flop chain for bringing an asynchronous comparator input into clk.
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/ovr_i_monitor.sv
// Counts consecutive PWM periods with an unblanked over-current and latches a
// motor shutdown once the count reaches TRIP_CNT.
module ovr_i_monitor
  import ovr_i_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned TRIP_CNT    = TRIP_CNT_DEF,
  parameter int unsigned CNT_W       = $clog2(TRIP_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             OVR_I,
  input  logic             PWM_synch,
  input  logic             ovr_I_blank,
  input  logic             clr_shdn,
  output logic             ovr_I_evt,
  output logic [CNT_W-1:0] flt_cnt,
  output logic             shutdown,
  output logic             mtr_en
);

  localparam logic [CNT_W-1:0] TRIP_VAL = CNT_W'(TRIP_CNT);

  ovr_state_t       state, state_d;
  logic [CNT_W-1:0] cnt_d, cnt_inc;
  logic             per_flag, per_flag_d;
  logic             ovr_s, qual, hit, clr_ok;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (OVR_I),
    .q     (ovr_s)
  );

  // Blank comes from the same clock domain, so it qualifies the sample directly.
  assign qual    = ovr_s & ~ovr_I_blank;
  assign hit     = per_flag | qual;
  assign cnt_inc = flt_cnt + CNT_W'(1);
  assign clr_ok  = (state == SHDN) & clr_shdn & ~ovr_s;

  always_comb begin
    state_d    = state;
    cnt_d      = flt_cnt;
    per_flag_d = per_flag;

    // A sample in the boundary cycle already went into hit for the ending period.
    if (PWM_synch)  per_flag_d = 1'b0;
    else if (qual)  per_flag_d = 1'b1;

    unique case (state)
      RUN: begin
        cnt_d = '0;
        if (PWM_synch && hit) begin
          cnt_d   = CNT_W'(1);
          state_d = (TRIP_CNT == 1) ? SHDN : FAULT;
        end
      end
      FAULT: begin
        if (PWM_synch) begin
          if (hit) begin
            cnt_d = cnt_inc;
            if (cnt_inc == TRIP_VAL) state_d = SHDN;
          end else begin
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
      SHDN: begin
        cnt_d = TRIP_VAL;
        if (clr_ok) begin
          state_d    = RUN;
          cnt_d      = '0;
          per_flag_d = 1'b0;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flt_cnt   <= '0;
      per_flag  <= 1'b0;
      ovr_I_evt <= 1'b0;
      shutdown  <= 1'b0;
      mtr_en    <= 1'b1;
    end else begin
      state     <= state_d;
      flt_cnt   <= cnt_d;
      per_flag  <= per_flag_d;
      ovr_I_evt <= qual & ~per_flag;
      shutdown  <= (state_d == SHDN);
      mtr_en    <= (state_d != SHDN);
    end
  end

endmodule

// File: tb/tb_ovr_i_monitor.sv
// Directed-plus-random bench for ovr_i_monitor driven by a PWM11 period model.
module tb_ovr_i_monitor;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned TRIP  = 4;
  localparam int unsigned CW    = $clog2(TRIP + 1);
  localparam int          PER   = 2048;
  localparam int          DUTY  = 1024;
  localparam int          BLANK = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          OVR_I = 1'b0;
  logic          PWM_synch = 1'b0;
  logic          ovr_I_blank = 1'b0;
  logic          clr_shdn = 1'b0;
  logic          ovr_I_evt;
  logic [CW-1:0] flt_cnt;
  logic          shutdown;
  logic          mtr_en;

  int n_vec = 0;
  int n_err = 0;
  int evt_seen = 0;
  int pcnt = 0;
  bit clr_req = 1'b0;

  // Reference model state: OVR_I sample history and a period-level fault tally.
  bit hist[$];
  bit m_flag;
  int m_cnt;
  bit m_shut;
  bit m_evt;

  always #5 clk = ~clk;

  ovr_i_monitor #(.SYNC_STAGES(SYNC), .TRIP_CNT(TRIP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .OVR_I       (OVR_I),
    .PWM_synch   (PWM_synch),
    .ovr_I_blank (ovr_I_blank),
    .clr_shdn    (clr_shdn),
    .ovr_I_evt   (ovr_I_evt),
    .flt_cnt     (flt_cnt),
    .shutdown    (shutdown),
    .mtr_en      (mtr_en)
  );

  function automatic bit in_blank(input int c);
    return (c >= 1 && c <= BLANK) || (c >= DUTY + 1 && c <= DUTY + BLANK);
  endfunction

  function automatic void model_reset();
    hist = {};
    for (int i = 0; i < int'(SYNC); i++) hist.push_front(1'b0);
    m_flag = 1'b0;
    m_cnt  = 0;
    m_shut = 1'b0;
    m_evt  = 1'b0;
  endfunction

  // Called once per clock edge with the inputs that edge saw.
  function automatic void model_edge(input bit ovr, input bit synch, input bit blank, input bit clr);
    bit ovr_seen;
    bit q;
    ovr_seen = hist[SYNC-1];
    q = ovr_seen && !blank;
    m_evt = q && !m_flag;
    if (m_shut) begin
      if (clr && !ovr_seen) begin
        m_shut = 1'b0;
        m_cnt  = 0;
        m_flag = 1'b0;
      end else if (synch) m_flag = 1'b0;
      else if (q) m_flag = 1'b1;
    end else if (synch) begin
      if (m_flag || q) begin
        m_cnt++;
        if (m_cnt == int'(TRIP)) m_shut = 1'b1;
      end else m_cnt = 0;
      m_flag = 1'b0;
    end else if (q) m_flag = 1'b1;
    hist.push_front(ovr);
    void'(hist.pop_back());
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: OVR_I is high when the PWM count lies in [lo, hi].
  task automatic step(input int lo, input int hi);
    OVR_I       = (pcnt >= lo && pcnt <= hi);
    PWM_synch   = (pcnt == 0);
    ovr_I_blank = in_blank(pcnt);
    clr_shdn    = clr_req;
    @(posedge clk);
    model_edge(OVR_I, PWM_synch, ovr_I_blank, clr_shdn);
    pcnt = (pcnt + 1) % PER;
    #1;
    if (ovr_I_evt === 1'b1) evt_seen++;
    chk("evt", 32'(ovr_I_evt), 32'(m_evt));
    chk("flt_cnt", 32'(flt_cnt), 32'(m_cnt));
    chk("shutdown", 32'(shutdown), 32'(m_shut));
    chk("mtr_en", 32'(mtr_en), 32'(!m_shut));
  endtask

  task automatic run_steps(input int n, input int lo, input int hi);
    for (int i = 0; i < n; i++) step(lo, hi);
  endtask

  // Runs to the end of the current PWM period.
  task automatic period(input int lo, input int hi);
    do step(lo, hi); while (pcnt != 0);
  endtask

  task automatic clean_period();
    period(1, 0);
  endtask

  task automatic fault_period();
    int lo;
    lo = int'($urandom_range(300, 900));
    period(lo, lo + int'($urandom_range(0, 19)));
  endtask

  task automatic blank_period();
    int lo;
    lo = int'($urandom_range(3, 20));
    if ($urandom_range(0, 1) == 1) lo += DUTY;
    period(lo, lo + int'($urandom_range(0, 90)));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_evt"}, 32'(ovr_I_evt), 32'd0);
    chk({tag, "_flt"}, 32'(flt_cnt), 32'd0);
    chk({tag, "_shdn"}, 32'(shutdown), 32'd0);
    chk({tag, "_mtr_en"}, 32'(mtr_en), 32'd1);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before the next edge.
  task automatic mid_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset(tag);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    check_reset("por");
    rst_n = 1'b1;

    // Over-current only inside blank windows never counts.
    repeat (10) blank_period();
    step(1, 0);
    chk("blank_flt", 32'(flt_cnt), 32'd0);
    chk("blank_evt", 32'(evt_seen), 32'd0);
    chk("blank_shdn", 32'(shutdown), 32'd0);
    clean_period();

    // Three faulted periods then a clean one.
    evt_seen = 0;
    repeat (3) fault_period();
    clean_period();
    chk("cnt3", 32'(flt_cnt), 32'd3);
    step(1, 0);
    chk("cnt_back0", 32'(flt_cnt), 32'd0);
    chk("evt_x3", 32'(evt_seen), 32'd3);

    // Four faulted periods trip the latch one cycle after the 4th boundary.
    repeat (4) fault_period();
    chk("pre_trip", 32'(shutdown), 32'd0);
    step(1, 0);
    chk("trip_shdn", 32'(shutdown), 32'd1);
    chk("trip_mtr_en", 32'(mtr_en), 32'd0);
    chk("trip_cnt", 32'(flt_cnt), 32'd4);
    clean_period();
    repeat (4) begin
      if ($urandom_range(0, 1) == 1) fault_period();
      else clean_period();
    end
    chk("hold_cnt", 32'(flt_cnt), 32'd4);
    chk("hold_shdn", 32'(shutdown), 32'd1);

    // Clear is refused while the synchronized comparator is still high.
    run_steps(6, 0, PER - 1);
    clr_req = 1'b1;
    step(0, PER - 1);
    clr_req = 1'b0;
    chk("clr_ignored", 32'(shutdown), 32'd1);
    run_steps(3, 1, 0);
    clr_req = 1'b1;
    step(1, 0);
    clr_req = 1'b0;
    chk("clr_shdn", 32'(shutdown), 32'd0);
    chk("clr_mtr_en", 32'(mtr_en), 32'd1);
    chk("clr_flt", 32'(flt_cnt), 32'd0);
    clean_period();

    // Qualified sample only in the boundary cycle counts for the ending period.
    period(PER - 2, PER - 2);
    step(1, 0);
    chk("edge_q_cnt", 32'(flt_cnt), 32'd1);
    clean_period();
    step(1, 0);
    chk("edge_q_clear", 32'(flt_cnt), 32'd0);
    clean_period();

    // Asynchronous reset with a partial count, then again while latched.
    repeat (3) fault_period();
    step(1, 0);
    chk("pre_rst_cnt", 32'(flt_cnt), 32'd3);
    run_steps(10, 1, 0);
    mid_reset("rst_cnt3");
    clean_period();
    repeat (4) fault_period();
    step(1, 0);
    chk("pre_rst_shdn", 32'(shutdown), 32'd1);
    mid_reset("rst_shdn");
    run_steps(20, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
